// File: rtl/matrix_stream_loader_if.sv
// Valid/ready element stream into matrix_stream_loader.
interface matrix_stream_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  element_valid;
  logic [DATA_WIDTH-1:0] element_data;
  logic                  element_ready;

  modport master (
    output element_valid,
    output element_data,
    input  element_ready
  );

  modport slave (
    input  element_valid,
    input  element_data,
    output element_ready
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Assembles two square matrices (A then B) from a row-major element stream,
// presents them in parallel, pulses start_operation once and waits for the
// adder's operation_complete before loading the next pair.
module matrix_stream_loader #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                                                 clock_signal,
  input  logic                                                 reset_signal,
  input  logic                                                 clear_request,
  matrix_stream_loader_if.slave                                elem_if,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] matrix_a_output,
  output logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] matrix_b_output,
  output logic                                                 start_operation,
  input  logic                                                 operation_complete,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE)-1:0]           element_index,
  output logic                                                 loader_busy
);

  localparam int IDX_W = $clog2(MATRIX_SIZE*MATRIX_SIZE);
  localparam int RC_W  = $clog2(MATRIX_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE*MATRIX_SIZE - 1);
  localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(MATRIX_SIZE - 1);

  typedef logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] mat_t;

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RC_W-1:0]  row_q, row_d;
  logic [RC_W-1:0]  col_q, col_d;
  mat_t             mat_a_q, mat_a_d;
  mat_t             mat_b_q, mat_b_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             xfer;

  // Row/column tracked alongside the flat index so no divider is needed.
  assign xfer = elem_if.element_valid && ready_q;

  // Next-state, index and matrix-write decode; clear wins over everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;

    if (clear_request) begin
      state_d = LOAD_A;
      idx_d   = '0;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        LOAD_A, LOAD_B: begin
          if (xfer) begin
            if (state_q == LOAD_A) begin
              mat_a_d[row_q][col_q] = elem_if.element_data;
            end else begin
              mat_b_d[row_q][col_q] = elem_if.element_data;
            end
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              row_d   = '0;
              col_d   = '0;
              state_d = (state_q == LOAD_A) ? LOAD_B : ISSUE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              if (col_q == LAST_RC) begin
                col_d = '0;
                row_d = row_q + RC_W'(1);
              end else begin
                col_d = col_q + RC_W'(1);
              end
            end
          end
        end
        ISSUE: begin
          state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (operation_complete) begin
            state_d = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
        end
      endcase
    end
  end

  // Status flags are registered from the next state: they track state_q
  // exactly but still read 0 while reset is held.
  always_comb begin
    ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    start_d = (state_d == ISSUE);
    busy_d  = (state_d == ISSUE) || (state_d == WAIT_DONE);
  end

  // State, counters, matrices and status registers.
  always_ff @(posedge clock_signal or negedge reset_signal) begin
    if (!reset_signal) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      ready_q <= ready_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign elem_if.element_ready = ready_q;
  assign matrix_a_output       = mat_a_q;
  assign matrix_b_output       = mat_b_q;
  assign start_operation       = start_q;
  assign element_index         = idx_q;
  assign loader_busy           = busy_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scenario bench for matrix_stream_loader with a pair scoreboard.
module tb_matrix_stream_loader;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
  typedef struct packed { mat_t a; mat_t b; } pair_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear_request;
  logic          operation_complete;
  mat_t          mat_a;
  mat_t          mat_b;
  logic          start_operation;
  logic          loader_busy;
  logic [IW-1:0] element_index;

  matrix_stream_loader_if #(.DATA_WIDTH(DW)) s_if ();

  matrix_stream_loader #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clock_signal       (clk),
    .reset_signal       (rst_n),
    .clear_request      (clear_request),
    .elem_if            (s_if),
    .matrix_a_output    (mat_a),
    .matrix_b_output    (mat_b),
    .start_operation    (start_operation),
    .operation_complete (operation_complete),
    .element_index      (element_index),
    .loader_busy        (loader_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned start_count = 0;
  always @(negedge clk) if (start_operation === 1'b1) start_count <= start_count + 1;

  int    checks = 0;
  int    errors = 0;
  pair_t exp_q[$];
  mat_t  last_a;

  function automatic mat_t build(input int unsigned base, input int unsigned step);
    mat_t m;
    for (int unsigned k = 0; k < NN; k++) m[k/N][k%N] = DW'(base + step * k);
    return m;
  endfunction

  task automatic send_elem(input logic [DW-1:0] d, output int unsigned acc_edge);
    int unsigned n = 0;
    @(negedge clk);
    s_if.element_valid = 1'b1;
    s_if.element_data  = d;
    while (s_if.element_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: element_ready=%b after %0d cycles, required 1", s_if.element_ready, n);
    end
    acc_edge = cyc + 1;
    @(posedge clk); #1;
    s_if.element_valid = 1'b0;
  endtask

  task automatic send_pair(input mat_t a, input mat_t b, input int unsigned gap,
                           output int unsigned first_edge);
    int unsigned e;
    pair_t p;
    p.a = a; p.b = b;
    exp_q.push_back(p);
    first_edge = 0;
    for (int unsigned k = 0; k < 2 * NN; k++) begin
      repeat (gap) @(negedge clk);
      if (k < NN) send_elem(a[k/N][k%N], e);
      else        send_elem(b[(k-NN)/N][(k-NN)%N], e);
      if (k == 0) first_edge = e;
    end
  endtask

  task automatic wait_start(output int unsigned se, output bit seen);
    seen = 1'b0;
    se   = 0;
    for (int unsigned i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (start_operation === 1'b1) begin
        seen = 1'b1;
        se   = cyc;
      end
    end
  endtask

  task automatic pulse_complete();
    @(negedge clk); operation_complete = 1'b1;
    @(negedge clk); operation_complete = 1'b0;
  endtask

  task automatic test_reset();
    s_if.element_valid = 1'b0; s_if.element_data = '0;
    clear_request = 1'b0; operation_complete = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_if.element_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", s_if.element_ready); end
    checks++; if (loader_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", loader_busy); end
    checks++; if (start_operation !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start_operation); end
    checks++; if (element_index !== '0) begin errors++; $display("FAIL reset_index: got %0d expected 0", element_index); end
    checks++; if (mat_a !== '0 || mat_b !== '0) begin errors++; $display("FAIL reset_mats: a=%h b=%h expected 0", mat_a, mat_b); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_if.element_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", s_if.element_ready); end
  endtask

  task automatic test_basic_load();
    int unsigned fe, se, sc0;
    bit          seen;
    bit          sum_ok;
    pair_t       p;
    sc0 = start_count;
    send_pair(build(1, 1), build(10, 0), 0, fe);
    wait_start(se, seen);
    checks++; if (!seen) begin errors++; $display("FAIL basic_start: start_operation never seen, required one pulse"); end
    checks++; if (se - fe + 2 != 33) begin errors++; $display("FAIL basic_latency: start in cycle %0d after first transfer, expected 33", se - fe + 2); end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL basic_scoreboard: queue empty, expected a pair");
    end else begin
      p = exp_q.pop_front();
      checks++; if (mat_a !== p.a) begin errors++; $display("FAIL basic_a: got %h expected %h", mat_a, p.a); end
      checks++; if (mat_b !== p.b) begin errors++; $display("FAIL basic_b: got %h expected %h", mat_b, p.b); end
    end
    checks++; if (mat_a[0][0] !== 8'd1)  begin errors++; $display("FAIL basic_a00: got %0d expected 1", mat_a[0][0]); end
    checks++; if (mat_a[1][2] !== 8'd7)  begin errors++; $display("FAIL basic_a12: got %0d expected 7", mat_a[1][2]); end
    checks++; if (mat_a[3][3] !== 8'd16) begin errors++; $display("FAIL basic_a33: got %0d expected 16", mat_a[3][3]); end
    sum_ok = 1'b1;
    for (int unsigned k = 0; k < NN; k++)
      if (DW'(mat_a[k/N][k%N] + mat_b[k/N][k%N]) !== DW'(11 + k)) sum_ok = 1'b0;
    checks++; if (!sum_ok) begin errors++; $display("FAIL basic_sums: a=%h b=%h, expected sums 11..26", mat_a, mat_b); end
    checks++; if (loader_busy !== 1'b1 || s_if.element_ready !== 1'b0) begin errors++; $display("FAIL basic_issue_flags: busy=%b ready=%b expected 1/0", loader_busy, s_if.element_ready); end
    @(negedge clk);
    checks++; if (start_operation !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: start=%b in WAIT_DONE, expected 0", start_operation); end
    pulse_complete();
    checks++; if (s_if.element_ready !== 1'b1 || loader_busy !== 1'b0) begin errors++; $display("FAIL basic_done: ready=%b busy=%b expected 1/0", s_if.element_ready, loader_busy); end
    checks++; if (start_count - sc0 != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", start_count - sc0); end
  endtask

  task automatic test_backpressure();
    mat_t        a, b;
    pair_t       p, q;
    int unsigned exp_idx, se, sc0;
    bit          seen;
    a = build(1, 1); b = build(10, 0);
    p.a = a; p.b = b;
    exp_q.push_back(p);
    sc0 = start_count;
    exp_idx = 0;
    for (int unsigned k = 0; k < 2 * NN; k++) begin
      repeat (2) begin
        @(negedge clk);
        checks++; if (element_index !== IW'(exp_idx)) begin errors++; $display("FAIL bp_index: element %0d got %0d expected %0d", k, element_index, exp_idx); end
      end
      @(negedge clk);
      s_if.element_valid = 1'b1;
      s_if.element_data  = (k < NN) ? a[k/N][k%N] : b[(k-NN)/N][(k-NN)%N];
      @(posedge clk); #1;
      s_if.element_valid = 1'b0;
      exp_idx = (exp_idx + 1) % NN;
    end
    wait_start(se, seen);
    checks++; if (!seen) begin errors++; $display("FAIL bp_start: start_operation never seen, required one pulse"); end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL bp_scoreboard: queue empty, expected a pair");
    end else begin
      q = exp_q.pop_front();
      checks++; if (mat_a !== q.a || mat_b !== q.b) begin errors++; $display("FAIL bp_mats: a=%h b=%h expected a=%h b=%h", mat_a, mat_b, q.a, q.b); end
    end
    pulse_complete();
    checks++; if (start_count - sc0 != 1) begin errors++; $display("FAIL bp_pulses: got %0d expected 1", start_count - sc0); end
  endtask

  task automatic test_busy_stall();
    mat_t        a, b, a2;
    pair_t       p;
    int unsigned fe, se, e;
    bit          seen;
    a = build(3, 3); b = build(50, 2);
    a2 = a; a2[0][0] = 8'h55;
    send_pair(a, b, 0, fe);
    fork
      send_elem(8'h55, e);
      begin
        wait_start(se, seen);
        checks++; if (!seen) begin errors++; $display("FAIL stall_start: start_operation never seen, required one pulse"); end
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL stall_scoreboard: queue empty, expected a pair");
        end else begin
          p = exp_q.pop_front();
          checks++; if (mat_a !== p.a || mat_b !== p.b) begin errors++; $display("FAIL stall_issue_mats: a=%h b=%h expected a=%h b=%h", mat_a, mat_b, p.a, p.b); end
        end
        for (int unsigned i = 0; i < 6; i++) begin
          checks++; if (s_if.element_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: cycle %0d got %b expected 0", i, s_if.element_ready); end
          checks++; if (mat_a !== a || mat_b !== b) begin errors++; $display("FAIL stall_hold: cycle %0d a=%h b=%h expected a=%h b=%h", i, mat_a, mat_b, a, b); end
          if (i < 5) @(negedge clk);
        end
        operation_complete = 1'b1;
        @(negedge clk);
        operation_complete = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (mat_a !== a2 || mat_b !== b) begin errors++; $display("FAIL stall_after: a=%h b=%h expected a=%h b=%h", mat_a, mat_b, a2, b); end
    checks++; if (element_index !== IW'(1)) begin errors++; $display("FAIL stall_index: got %0d expected 1", element_index); end
    clear_request = 1'b1;
    @(negedge clk);
    clear_request = 1'b0;
    checks++; if (element_index !== '0) begin errors++; $display("FAIL stall_clear_index: got %0d expected 0", element_index); end
    checks++; if (mat_a !== a2) begin errors++; $display("FAIL stall_clear_retain: got %h expected %h", mat_a, a2); end
    last_a = a2;
  endtask

  task automatic test_clear_mid_load();
    mat_t        pre, na, nb;
    pair_t       p;
    int unsigned e, fe, se, sc0;
    bit          seen;
    pre = last_a;
    for (int unsigned k = 0; k < 5; k++) begin
      send_elem(DW'(101 + k), e);
      pre[k/N][k%N] = DW'(101 + k);
    end
    @(negedge clk);
    checks++; if (element_index !== IW'(5)) begin errors++; $display("FAIL clear_pre_index: got %0d expected 5", element_index); end
    s_if.element_valid = 1'b1; s_if.element_data = 8'd99; clear_request = 1'b1;
    @(posedge clk); #1;
    s_if.element_valid = 1'b0; clear_request = 1'b0;
    @(negedge clk);
    checks++; if (element_index !== '0) begin errors++; $display("FAIL clear_index: got %0d expected 0", element_index); end
    checks++; if (mat_a[1][1] === 8'd99) begin errors++; $display("FAIL clear_drop: A[1][1] got %0d expected %0d", mat_a[1][1], pre[1][1]); end
    checks++; if (mat_a !== pre) begin errors++; $display("FAIL clear_retain: got %h expected %h", mat_a, pre); end
    checks++; if (s_if.element_ready !== 1'b1 || start_operation !== 1'b0) begin errors++; $display("FAIL clear_flags: ready=%b start=%b expected 1/0", s_if.element_ready, start_operation); end
    na = build(20, 1); nb = build(7, 5);
    sc0 = start_count;
    send_pair(na, nb, 0, fe);
    wait_start(se, seen);
    checks++; if (!seen) begin errors++; $display("FAIL clear_start: start_operation never seen, required one pulse"); end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL clear_scoreboard: queue empty, expected a pair");
    end else begin
      p = exp_q.pop_front();
      checks++; if (mat_a !== p.a || mat_b !== p.b) begin errors++; $display("FAIL clear_mats: a=%h b=%h expected a=%h b=%h", mat_a, mat_b, p.a, p.b); end
    end
    pulse_complete();
    checks++; if (start_count - sc0 != 1) begin errors++; $display("FAIL clear_pulses: got %0d expected 1", start_count - sc0); end
  endtask

  task automatic test_async_reset();
    pair_t       p;
    int unsigned fe, se, sc0;
    bit          seen;
    send_pair(build(9, 1), build(1, 1), 0, fe);
    wait_start(se, seen);
    checks++; if (!seen) begin errors++; $display("FAIL ar_start: start_operation never seen, required one pulse"); end
    if (exp_q.size() == 0) begin
      checks++; errors++; $display("FAIL ar_scoreboard: queue empty, expected a pair");
    end else begin
      p = exp_q.pop_front();
      checks++; if (mat_a !== p.a || mat_b !== p.b) begin errors++; $display("FAIL ar_mats: a=%h b=%h expected a=%h b=%h", mat_a, mat_b, p.a, p.b); end
    end
    @(posedge clk); #2;
    checks++; if (loader_busy !== 1'b1) begin errors++; $display("FAIL ar_wait_busy: got %b expected 1", loader_busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mat_a !== '0 || mat_b !== '0) begin errors++; $display("FAIL ar_mats_zero: a=%h b=%h expected 0", mat_a, mat_b); end
    checks++; if (loader_busy !== 1'b0 || start_operation !== 1'b0) begin errors++; $display("FAIL ar_flags: busy=%b start=%b expected 0/0", loader_busy, start_operation); end
    checks++; if (element_index !== '0 || s_if.element_ready !== 1'b0) begin errors++; $display("FAIL ar_idx_ready: idx=%0d ready=%b expected 0/0", element_index, s_if.element_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    sc0 = start_count;
    pulse_complete();
    repeat (3) begin
      @(negedge clk);
      checks++; if (loader_busy !== 1'b0 || s_if.element_ready !== 1'b1 || element_index !== '0) begin errors++; $display("FAIL ar_late_complete: busy=%b ready=%b idx=%0d expected 0/1/0", loader_busy, s_if.element_ready, element_index); end
    end
    checks++; if (start_count != sc0) begin errors++; $display("FAIL ar_pulses: got %0d extra pulses expected 0", start_count - sc0); end
  endtask

  task automatic test_back_to_back();
    int unsigned sc0, fe1, fe2, se;
    bit          seen;
    pair_t       p;
    sc0 = start_count;
    fork
      begin
        send_pair(build(2, 2), build(40, 1), 0, fe1);
        send_pair(build(90, 3), build(5, 7), 0, fe2);
      end
      begin
        for (int unsigned n = 0; n < 2; n++) begin
          wait_start(se, seen);
          checks++; if (!seen) begin errors++; $display("FAIL b2b_start: pair %0d start never seen", n); end
          if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL b2b_scoreboard: pair %0d queue empty", n);
          end else begin
            p = exp_q.pop_front();
            checks++; if (mat_a !== p.a || mat_b !== p.b) begin errors++; $display("FAIL b2b_mats: pair %0d a=%h b=%h expected a=%h b=%h", n, mat_a, mat_b, p.a, p.b); end
          end
          repeat (2) @(negedge clk);
          operation_complete = 1'b1;
          @(negedge clk);
          operation_complete = 1'b0;
        end
      end
    join
    @(negedge clk);
    checks++; if (start_count - sc0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", start_count - sc0); end
    checks++; if (s_if.element_ready !== 1'b1 || loader_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready=%b busy=%b expected 1/0", s_if.element_ready, loader_busy); end
  endtask

  initial begin
    s_if.element_valid = 1'b0;
    s_if.element_data  = '0;
    clear_request      = 1'b0;
    operation_complete = 1'b0;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_busy_stall();
    test_clear_mid_load();
    test_async_reset();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: %0d pairs left expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for matrix_adder_processor.
- Accepts a serial stream of DATA_WIDTH elements over a valid/ready handshake, in row-major order: first all of matrix A, then all of matrix B.
- Once both matrices are assembled, holds them on parallel outputs, issues a one-cycle start_operation pulse, and waits for the adder's operation_complete before accepting the next pair.

Parameters:
- MATRIX_SIZE, 4, rows = columns of each square matrix; legal range 2..15.
- DATA_WIDTH, 8, bits per element.

Ports:
- clock_signal  input  1  single clock; all state updates on the rising edge.
- reset_signal  input  1  asynchronous, active-low reset.
- clear_request  input  1  synchronous abort of the current load.
- element_valid  input  1  element_data is valid this cycle.
- element_data  input  DATA_WIDTH  streamed matrix element.
- element_ready  output  1  loader can accept an element this cycle.
- matrix_a_output  output  DATA_WIDTH x [MATRIX_SIZE][MATRIX_SIZE]  assembled matrix A.
- matrix_b_output  output  DATA_WIDTH x [MATRIX_SIZE][MATRIX_SIZE]  assembled matrix B.
- start_operation  output  1  one-cycle pulse to the adder.
- operation_complete  input  1  completion pulse from the adder.
- element_index  output  $clog2(MATRIX_SIZE*MATRIX_SIZE)  row-major index of the next element expected.
- loader_busy  output  1  high in ISSUE and WAIT_DONE.

Behaviour:
- Reset (reset_signal low, asynchronous):
  - State = LOAD_A.
  - element_index = 0.
  - All matrix_a_output and matrix_b_output entries = 0.
  - start_operation = 0, loader_busy = 0.
  - element_ready = 0 while reset is asserted; it reads 1 in the first cycle after release.
- States: LOAD_A, LOAD_B, ISSUE, WAIT_DONE.
- element_ready = 1 exactly in LOAD_A and LOAD_B. It is decoded from the state register only, with no combinational path from element_valid.
- Transfer:
  - A transfer occurs on a rising edge where element_valid && element_ready.
  - The element at index k is written to row k / MATRIX_SIZE, column k % MATRIX_SIZE of the matrix for the current state.
  - element_index then increments.
- Phase transitions:
  - In LOAD_A, when the transfer at k = N*N-1 occurs: element_index wraps to 0 and the next state is LOAD_B.
  - In LOAD_B, when the transfer at k = N*N-1 occurs: element_index wraps to 0 and the next state is ISSUE.
- ISSUE:
  - Lasts exactly one cycle; start_operation = 1 (registered) for that cycle only.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - Remains until operation_complete = 1 is sampled, then goes to LOAD_A.
  - element_ready returns to 1 one cycle after operation_complete is sampled.
- Matrix outputs:
  - Stable and unchanged from the ISSUE cycle through WAIT_DONE.
  - They change only on transfers.
  - They retain their last values after completion until overwritten element by element.
- operation_complete sampled in LOAD_A, LOAD_B or ISSUE is ignored.
- clear_request = 1 (any state):
  - Next state = LOAD_A, element_index = 0, start_operation = 0.
  - Matrix contents are retained, not zeroed.
  - clear_request has priority over a simultaneous transfer; that element is dropped.
  - clear_request has priority over the ISSUE pulse.
- Backpressure: element_valid may deassert at any time. A stalled cycle changes no state.
- element_data is stored unmodified; no arithmetic is performed in this block.
- Latency: the ISSUE cycle immediately follows the edge that accepts the last B element. The minimum for one pair is 2*N*N + 1 cycles from the first accepted A element to start_operation.
- Reset asserted mid-operation (any state) returns all outputs to their reset values immediately. A later operation_complete from the adder lands in LOAD_A and is ignored.

Test Plan:
- Basic load, N=4:
  - Stimulus: A elements 1..16, then 16 B elements all 10, element_valid held high.
  - Required: matrix_a_output[0][0]=1, [1][2]=7, [3][3]=16; all B entries = 10.
  - start_operation high for exactly one cycle, 33 cycles after the first A transfer.
  - The downstream adder returns 11..26 row-major.
- Backpressure:
  - Stimulus: element_valid asserted every third cycle, same data as the basic load.
  - Required: identical matrices; element_index advances only on accepted cycles; one start pulse.
- Busy stall:
  - Stimulus: element_valid held high with data 0x55 during ISSUE and WAIT_DONE; operation_complete delayed 5 cycles.
  - Required: element_ready = 0 and no matrix change during the stall.
  - The first 0x55 lands in A[0][0] only after operation_complete.
- Clear mid-load:
  - Stimulus: after 5 A elements, clear_request is pulsed in the same cycle as a valid element of 99; then a full new sequence is sent.
  - Required: 99 is not stored; element_index = 0 after the clear.
  - The new sequence fills from A[0][0]; exactly one start pulse.
- Async reset in WAIT_DONE:
  - Stimulus: reset_signal driven low mid-cycle.
  - Required: matrices = 0, state LOAD_A, loader_busy = 0, without waiting for a clock edge.
  - A late operation_complete causes no transition.
- Back-to-back pairs:
  - Stimulus: two full pairs streamed; operation_complete pulsed 2 cycles after each start.
  - Required: two start pulses; the second pair's values appear on the outputs in the second ISSUE cycle.
